// File: rtl/reg_write_arbiter.sv
// Two-requester register-write arbiter with five 8-bit control registers (addresses 0x00-0x04).
// Define ARB_ROUND_ROBIN_EN for round-robin contention; the default is fixed priority to req0.
module reg_write_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [6:0] req0_addr,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [6:0] req1_addr,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_err
);

  typedef enum logic {StIdle, StCommit} state_e;

  state_e     state_q, state_d;
  logic       winner_q, winner_d;
  logic       last_grant_q, last_grant_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [7:0] out_lo_q, out_lo_d;
  logic [7:0] out_hi_q, out_hi_d;
  logic [7:0] pwm_lo_q, pwm_lo_d;
  logic [7:0] pwm_hi_q, pwm_hi_d;
  logic [7:0] duty_q, duty_d;
  logic       win;

  // Winner among currently valid requesters; a lone requester always wins.
  always_comb begin
    if (req0_valid && req1_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
      win = ~last_grant_q;
`else
      win = 1'b0;
`endif
    end else begin
      win = req1_valid;
    end
  end

  always_comb begin
    state_d      = state_q;
    winner_d     = winner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    data_d       = data_q;
    out_lo_d     = out_lo_q;
    out_hi_d     = out_hi_q;
    pwm_lo_d     = pwm_lo_q;
    pwm_hi_d     = pwm_hi_q;
    duty_d       = duty_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    wr_err       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req0_valid || req1_valid) begin
          state_d  = StCommit;
          winner_d = win;
          addr_d   = win ? req1_addr : req0_addr;
          data_d   = win ? req1_data : req0_data;
        end
      end
      StCommit: begin
        req0_ready   = ~winner_q;
        req1_ready   = winner_q;
        wr_err       = (addr_q > 7'h04);
        state_d      = StIdle;
        last_grant_d = winner_q;
        case (addr_q)
          7'h00:   out_lo_d = data_q;
          7'h01:   out_hi_d = data_q;
          7'h02:   pwm_lo_d = data_q;
          7'h03:   pwm_hi_d = data_q;
          7'h04:   duty_d   = data_q;
          default: ;
        endcase
      end
    endcase
  end

  // last_grant resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      winner_q     <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= 7'h00;
      data_q       <= 8'h00;
      out_lo_q     <= 8'h00;
      out_hi_q     <= 8'h00;
      pwm_lo_q     <= 8'h00;
      pwm_hi_q     <= 8'h00;
      duty_q       <= 8'h00;
    end else begin
      state_q      <= state_d;
      winner_q     <= winner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      out_lo_q     <= out_lo_d;
      out_hi_q     <= out_hi_d;
      pwm_lo_q     <= pwm_lo_d;
      pwm_hi_q     <= pwm_hi_d;
      duty_q       <= duty_d;
    end
  end

  assign en_reg_out_7_0  = out_lo_q;
  assign en_reg_out_15_8 = out_hi_q;
  assign en_reg_pwm_7_0  = pwm_lo_q;
  assign en_reg_pwm_15_8 = pwm_hi_q;
  assign pwm_duty_cycle  = duty_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: expected grants are queued when requests are driven and
// popped when a ready strobe appears; a register model is compared on the cycle after each commit.
module tb_reg_write_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [6:0] req0_addr, req1_addr;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       wr_err;

  int n_checks = 0;
  int n_errors = 0;
  int cycle = 0;
  int last_ready_cycle = 0;
  int ready_gap = 0;
  bit reg_chk_pending = 1'b0;
  logic [15:0] sb_q[$];
  logic [7:0]  model[5];

  always #5 clk = ~clk;

  reg_write_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req0_valid     (req0_valid),
    .req0_addr      (req0_addr),
    .req0_data      (req0_data),
    .req0_ready     (req0_ready),
    .req1_valid     (req1_valid),
    .req1_addr      (req1_addr),
    .req1_data      (req1_data),
    .req1_ready     (req1_ready),
    .en_reg_out_7_0 (en_reg_out_7_0),
    .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0 (en_reg_pwm_7_0),
    .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle (pwm_duty_cycle),
    .wr_err         (wr_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_regs();
    check_eq("en_reg_out_7_0", 32'(en_reg_out_7_0), 32'(model[0]));
    check_eq("en_reg_out_15_8", 32'(en_reg_out_15_8), 32'(model[1]));
    check_eq("en_reg_pwm_7_0", 32'(en_reg_pwm_7_0), 32'(model[2]));
    check_eq("en_reg_pwm_15_8", 32'(en_reg_pwm_15_8), 32'(model[3]));
    check_eq("pwm_duty_cycle", 32'(pwm_duty_cycle), 32'(model[4]));
  endtask

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  // Monitor: pop one expectation per ready strobe, check registers the following cycle.
  initial forever begin
    logic [15:0] exp;
    int a;
    @(negedge clk);
    if (rst_n) begin
      if (reg_chk_pending) begin
        reg_chk_pending = 1'b0;
        check_regs();
      end
      if (req0_ready || req1_ready) begin
        check_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          exp = sb_q.pop_front();
          a   = int'(exp[14:8]);
          check_eq("grant", 32'({req1_ready, req0_ready}), exp[15] ? 32'd2 : 32'd1);
          check_eq("wr_err", 32'(wr_err), 32'(a > 4));
          if (a < 5) model[a] = exp[7:0];
          reg_chk_pending  = 1'b1;
          ready_gap        = cycle - last_ready_cycle;
          last_ready_cycle = cycle;
        end
      end else begin
        check_eq("wr_err_idle", 32'(wr_err), 32'd0);
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that closes the commit.
  task automatic do_write(input bit idx, input logic [6:0] a, input logic [7:0] d);
    bit seen = 1'b0;
    if (idx) begin
      req1_valid = 1'b1; req1_addr = a; req1_data = d;
    end else begin
      req0_valid = 1'b1; req0_addr = a; req0_data = d;
    end
    sb_q.push_back({idx, a, d});
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = idx ? req1_ready : req0_ready;
    end
    check_eq("ready_seen", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    if (idx) req1_valid = 1'b0;
    else     req0_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    for (int i = 0; i < 5; i++) model[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_regs();
    check_eq("reset_ready", 32'({req1_ready, req0_ready}), 32'd0);
    check_eq("reset_wr_err", 32'(wr_err), 32'd0);
    rst_n = 1'b1;

    do_write(1'b0, 7'h04, 8'hA5);
    do_write(1'b1, 7'h02, 8'h3C);

    // Continuous contention for four grant slots.
    req0_valid = 1'b1; req0_addr = 7'h00; req0_data = 8'h11;
    req1_valid = 1'b1; req1_addr = 7'h01; req1_data = 8'h22;
`ifdef ARB_ROUND_ROBIN_EN
    sb_q.push_back({1'b0, 7'h00, 8'h11});
    sb_q.push_back({1'b1, 7'h01, 8'h22});
    sb_q.push_back({1'b0, 7'h00, 8'h11});
    sb_q.push_back({1'b1, 7'h01, 8'h22});
`else
    for (int i = 0; i < 4; i++) sb_q.push_back({1'b0, 7'h00, 8'h11});
`endif
    repeat (8) @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;

    do_write(1'b0, 7'h05, 8'hFF);

    // Reset lands during the commit of a req1 write; the write must be dropped.
    req1_valid = 1'b1; req1_addr = 7'h03; req1_data = 8'h55;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("abort_ready", 32'({req1_ready, req0_ready}), 32'd0);
    check_eq("abort_wr_err", 32'(wr_err), 32'd0);
    req1_valid = 1'b0;
    for (int i = 0; i < 5; i++) model[i] = 8'h00;
    reg_chk_pending = 1'b0;
    @(posedge clk);
    #1;
    check_eq("abort_pwm_15_8", 32'(en_reg_pwm_15_8), 32'd0);
    rst_n = 1'b1;

    req0_valid = 1'b1; req0_addr = 7'h00; req0_data = 8'h11;
    req1_valid = 1'b1; req1_addr = 7'h01; req1_data = 8'h22;
    sb_q.push_back({1'b0, 7'h00, 8'h11});
    repeat (2) @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    check_eq("post_reset_pwm_15_8", 32'(en_reg_pwm_15_8), 32'd0);

    do_write(1'b0, 7'h00, 8'h01);
    do_write(1'b0, 7'h00, 8'h02);
    check_eq("b2b_gap", 32'(ready_gap), 32'd2);

    repeat (3) @(posedge clk);
    #1;
    check_eq("final_out_7_0", 32'(en_reg_out_7_0), 32'h02);
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
